// File: rtl/fx2_loopback_p.sv
// FX2 slave-FIFO packet loopback: reads a packet from the OUT endpoint into a buffer and writes it back to the IN endpoint.
// Optional macro FX2_PKTEND_EN: commits short packets with a one-cycle PKTEND strobe after the write phase.
module fx2_loopback_p #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH       = 256,
  parameter logic [1:0]  RD_EP       = 2'b00,
  parameter logic [1:0]  WR_EP       = 2'b10,
  parameter int unsigned STARTUP_CYC = 16
) (
  input  logic                       clk,
  input  logic                       clk_locked,
  output logic                       ifclk,
  inout  wire logic [DATA_W-1:0]     data,
  output logic [1:0]                 addr,
  output logic                       slrd,
  output logic                       slwr,
  output logic                       sloe,
  output logic                       pktend,
  input  logic                       flag_ef,
  input  logic                       flag_ff,
  output logic                       done,
  output logic [15:0]                pkt_count,
  output logic [$clog2(DEPTH):0]     last_len
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_RD,
    ST_TURN,
    ST_SEL_WR,
    ST_WR,
    ST_PKTEND
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     su_q;
  logic              done_q;
  logic [CW-1:0]     cnt_q;
  logic [AW-1:0]     idx_q;
  logic [15:0]       pkt_cnt_q;
  logic [CW-1:0]     last_len_q;
  logic              sloe_q;
  logic [1:0]        addr_q;
  logic              drv_q;
  logic              rd_fire;
  logic              wr_fire;
  logic              last_wr;
  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    rd_fire = (state_q == ST_RD) && flag_ef && (cnt_q < CW'(DEPTH));
    wr_fire = (state_q == ST_WR) && flag_ff;
    last_wr = wr_fire && ((CW'(idx_q) + CW'(1)) == cnt_q);
    state_d = state_q;
    unique case (state_q)
      ST_STARTUP: if (su_q == SW'(STARTUP_CYC - 1)) state_d = ST_IDLE;
      ST_IDLE:    if (flag_ef) state_d = ST_RD;
      // An empty read burst has nothing to return, so skip the write phase.
      ST_RD:      if (!rd_fire) state_d = (cnt_q == '0) ? ST_IDLE : ST_TURN;
      ST_TURN:    state_d = ST_SEL_WR;
      ST_SEL_WR:  state_d = ST_WR;
      ST_WR: begin
        if (last_wr) begin
`ifdef FX2_PKTEND_EN
          state_d = (cnt_q < CW'(DEPTH)) ? ST_PKTEND : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_PKTEND:  state_d = ST_IDLE;
      default:    state_d = ST_STARTUP;
    endcase
  end

  // Output registers are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!clk_locked) begin
      state_q    <= ST_STARTUP;
      su_q       <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      pkt_cnt_q  <= '0;
      last_len_q <= '0;
      sloe_q     <= 1'b1;
      addr_q     <= RD_EP;
      drv_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_STARTUP) su_q <= su_q + 1'b1;
      if (state_q == ST_STARTUP && state_d == ST_IDLE) done_q <= 1'b1;
      if (rd_fire) cnt_q <= cnt_q + 1'b1;
      if (wr_fire) idx_q <= idx_q + 1'b1;
      if (last_wr) begin
        pkt_cnt_q  <= pkt_cnt_q + 16'd1;
        last_len_q <= cnt_q;
        cnt_q      <= '0;
        idx_q      <= '0;
      end
      sloe_q <= (state_d != ST_RD);
      addr_q <= (state_d == ST_SEL_WR || state_d == ST_WR || state_d == ST_PKTEND) ? WR_EP : RD_EP;
      drv_q  <= (state_d == ST_WR);
    end
  end

`ifdef FX2_PKTEND_EN
  logic pktend_q;

  always_ff @(posedge clk) begin
    if (!clk_locked) pktend_q <= 1'b1;
    else             pktend_q <= (state_d != ST_PKTEND);
  end

  assign pktend = pktend_q;
`else
  assign pktend = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rd_fire) mem[cnt_q[AW-1:0]] <= data;
  end

  assign ifclk     = ~clk;
  assign data      = drv_q ? mem[idx_q] : 'z;
  assign addr      = addr_q;
  assign sloe      = sloe_q;
  assign slrd      = ~rd_fire;
  assign slwr      = ~wr_fire;
  assign done      = done_q;
  assign pkt_count = pkt_cnt_q;
  assign last_len  = last_len_q;

endmodule

// File: tb/tb_fx2_loopback_p.sv
// Self-checking bench for fx2_loopback_p: an FX2 FIFO model feeds random packets and checks the looped-back stream.
module tb_fx2_loopback_p;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 256;
  localparam logic [1:0]  RD_EP = 2'b00;
  localparam logic [1:0]  WR_EP = 2'b10;
`ifdef FX2_PKTEND_EN
  localparam bit PE_ON = 1'b1;
`else
  localparam bit PE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clk_locked = 1'b0;
  logic          flag_ef = 1'b0;
  logic          flag_ff = 1'b1;
  logic          ifclk, slrd, slwr, sloe, pktend, done;
  logic [1:0]    addr;
  logic [15:0]   pkt_count;
  logic [8:0]    last_len;
  logic [DW-1:0] tb_dq = '0;
  wire  [DW-1:0] data;

  // The FX2 drives the bus only while the host asserts SLOE.
  assign data = sloe ? 'z : tb_dq;

  always #5 clk = ~clk;

  fx2_loopback_p #(
    .DATA_W(DW), .DEPTH(DEPTH), .RD_EP(RD_EP), .WR_EP(WR_EP), .STARTUP_CYC(16)
  ) dut (
    .clk(clk), .clk_locked(clk_locked), .ifclk(ifclk), .data(data), .addr(addr),
    .slrd(slrd), .slwr(slwr), .sloe(sloe), .pktend(pktend),
    .flag_ef(flag_ef), .flag_ff(flag_ff), .done(done),
    .pkt_count(pkt_count), .last_len(last_len)
  );

  int unsigned   errors = 0;
  int unsigned   checks = 0;
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  int unsigned   pe_cnt = 0, exp_pe = 0, exp_last = 0;
  logic [15:0]   exp_pkts = '0;
  int            ef_pulse = 0, stall_left = 0, stall_at = -1;
  bit            rand_stall = 1'b0;
  bit            rd_c = 1'b0, wr_c = 1'b0, pe_c = 1'b0;
  logic [DW-1:0] wd_c = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: retire the strobes seen before the last edge, drive new inputs, sample the next strobes.
  task automatic tick();
    @(negedge clk);
    if (rd_c && out_q.size() != 0) void'(out_q.pop_front());
    if (wr_c) got_q.push_back(wd_c);
    if (pe_c) pe_cnt++;
    if (stall_at >= 0 && got_q.size() == stall_at) begin
      stall_left = 3;
      stall_at   = -1;
    end
    if (stall_left > 0) begin
      flag_ff = 1'b0;
      stall_left--;
    end else begin
      flag_ff = rand_stall ? ($urandom_range(3) != 0) : 1'b1;
    end
    if (ef_pulse > 0) begin
      flag_ef = 1'b1;
      ef_pulse--;
    end else begin
      flag_ef = (out_q.size() != 0);
    end
    tb_dq = (out_q.size() != 0) ? out_q[0] : '0;
    #1;
    rd_c = !slrd;
    wr_c = !slwr;
    pe_c = !pktend;
    wd_c = data;
    if (!slrd) begin
      check("rd_sloe", sloe, 0);
      check("rd_addr", addr, RD_EP);
      check("rd_avail", out_q.size() != 0, 1);
    end
    if (!slwr) begin
      check("wr_sloe", sloe, 1);
      check("wr_addr", addr, WR_EP);
      check("wr_room", flag_ff, 1);
    end
    if (!pktend) check("pe_addr", addr, WR_EP);
  endtask

  task automatic add_word(input logic [DW-1:0] w);
    out_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Words already queued form a continuous burst: it is returned as DEPTH-sized packets plus a short tail.
  task automatic run_burst(input int unsigned n);
    int unsigned full, rem, budget;
    full   = n / DEPTH;
    rem    = n % DEPTH;
    exp_pkts = exp_pkts + 16'(full + ((rem != 0) ? 1 : 0));
    exp_last = (rem != 0) ? rem : DEPTH;
    if (PE_ON && rem != 0) exp_pe++;
    budget = 8 * n + 40;
    while (got_q.size() < exp_q.size() && budget > 0) begin
      tick();
      budget--;
    end
    repeat (4) tick();
    check("burst_len", got_q.size(), exp_q.size());
    for (int unsigned i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check("word", got_q[i], exp_q[i]);
    check("pkt_count", pkt_count, exp_pkts);
    check("last_len", last_len, exp_last);
    check("pktend_cnt", pe_cnt, exp_pe);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic startup(input string tag);
    int unsigned n;
    bit          quiet;
    n     = 0;
    quiet = 1'b1;
    clk_locked = 1'b1;
    while (!done && n < 40) begin
      tick();
      n++;
      if (!(slrd && slwr && sloe && pktend)) quiet = 1'b0;
    end
    check(tag, n, 16);
    check("startup_quiet", quiet, 1);
  endtask

  task automatic reset_vals();
    check("rst_slrd", slrd, 1);
    check("rst_slwr", slwr, 1);
    check("rst_sloe", sloe, 1);
    check("rst_pktend", pktend, 1);
    check("rst_addr", addr, RD_EP);
    check("rst_done", done, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_last_len", last_len, 0);
  endtask

  initial begin
    int unsigned budget;
    repeat (4) tick();
    reset_vals();
    startup("startup_cycles");

    add_word(16'h0F01);
    add_word(16'h00F2);
    run_burst(2);

    stall_at = 2;
    for (int unsigned i = 1; i <= 4; i++) add_word(16'(i));
    run_burst(4);

    ef_pulse = 1;
    repeat (6) tick();
    check("spurious_wr", got_q.size(), 0);
    check("spurious_pkt", pkt_count, exp_pkts);

    for (int unsigned i = 0; i < DEPTH; i++) add_word(16'(i));
    for (int unsigned i = 0; i < 4; i++) add_word(16'($urandom));
    run_burst(DEPTH + 4);

    rand_stall = 1'b1;
    for (int unsigned b = 0; b < 6; b++) begin
      int unsigned len;
      len = $urandom_range(24, 1);
      for (int unsigned i = 0; i < len; i++) add_word(16'($urandom));
      run_burst(len);
    end
    for (int unsigned i = 0; i < DEPTH; i++) add_word(16'($urandom));
    run_burst(DEPTH);
    rand_stall = 1'b0;

    for (int unsigned i = 0; i < 8; i++) add_word(16'($urandom));
    budget = 200;
    while (got_q.size() < 3 && budget > 0) begin
      tick();
      budget--;
    end
    check("pre_reset_words", got_q.size(), 3);
    clk_locked = 1'b0;
    tick();
    reset_vals();
    out_q.delete();
    got_q.delete();
    exp_q.delete();
    exp_pkts = '0;
    exp_pe   = 0;
    pe_cnt   = 0;
    rd_c     = 1'b0;
    wr_c     = 1'b0;
    pe_c     = 1'b0;
    repeat (2) tick();
    startup("restart_cycles");

    for (int unsigned i = 0; i < 5; i++) add_word(16'($urandom));
    run_burst(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
